// File: rtl/shift_reg_univ_if.sv
// Bus for the universal shift register: control/data inputs and register outputs.
// The master side drives mode/data; the slave side is the shift register itself.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             clr;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic             rot;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    cnt;
    logic             done;

    modport master (
        output clr, mode, sin_r, sin_l, pin, rot,
        input  q, sout_r, sout_l, cnt, done
    );

    modport slave (
        input  clr, mode, sin_r, sin_l, pin, rot,
        output q, sout_r, sout_l, cnt, done
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift right / shift left / parallel load, with
// registered serial outs, a saturating shift counter and a done pulse. SHIFT_ROTATE_EN enables rotate.
module shift_reg_univ #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    shift_reg_univ_if.slave io_bus
);

    typedef enum logic [1:0] {
        M_HOLD = 2'b00,
        M_SHR  = 2'b01,
        M_SHL  = 2'b10,
        M_LOAD = 2'b11
    } mode_e;

    localparam logic [CW-1:0] LP_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] LP_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_sout_r;
    logic             r_sout_l;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    mode_e            w_mode;
    logic             w_fill_r;
    logic             w_fill_l;
    logic             w_shift;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_sout_r_nxt;
    logic             w_sout_l_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_done_nxt;

    assign w_mode = mode_e'(io_bus.mode);

`ifdef SHIFT_ROTATE_EN
    // Rotation feeds the bit leaving the far end back in instead of the serial input.
    assign w_fill_r = io_bus.rot ? r_q[0]       : io_bus.sin_r;
    assign w_fill_l = io_bus.rot ? r_q[WIDTH-1] : io_bus.sin_l;
`else
    logic w_unused_rot;
    assign w_unused_rot = io_bus.rot;
    assign w_fill_r     = io_bus.sin_r;
    assign w_fill_l     = io_bus.sin_l;
`endif

    always_comb begin
        w_q_nxt      = r_q;
        w_sout_r_nxt = r_sout_r;
        w_sout_l_nxt = r_sout_l;
        w_shift      = 1'b0;
        case (w_mode)
            M_SHR: begin
                w_q_nxt      = {w_fill_r, r_q[WIDTH-1:1]};
                w_sout_r_nxt = r_q[0];
                w_shift      = 1'b1;
            end
            M_SHL: begin
                w_q_nxt      = {r_q[WIDTH-2:0], w_fill_l};
                w_sout_l_nxt = r_q[WIDTH-1];
                w_shift      = 1'b1;
            end
            M_LOAD:  w_q_nxt = io_bus.pin;
            default: ;
        endcase
    end

    // Both shift directions share one counter; a hold leaves the frame intact.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_done_nxt = 1'b0;
        if (w_mode == M_LOAD) begin
            w_cnt_nxt = '0;
        end else if (w_shift) begin
            w_done_nxt = (r_cnt == LP_LAST);
            if (r_cnt != LP_FULL) w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q      <= '0;
            r_sout_r <= 1'b0;
            r_sout_l <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else if (io_bus.clr) begin
            r_q      <= '0;
            r_sout_r <= 1'b0;
            r_sout_l <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_q      <= w_q_nxt;
            r_sout_r <= w_sout_r_nxt;
            r_sout_l <= w_sout_l_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign io_bus.q      = r_q;
    assign io_bus.sout_r = r_sout_r;
    assign io_bus.sout_l = r_sout_l;
    assign io_bus.cnt    = r_cnt;
    assign io_bus.done   = r_done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: WIDTH=4 and WIDTH=8 instances, a word-level model checked
// every cycle, and directed scenarios with literal expectations.
module tb_shift_reg_univ;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_reg_univ_if #(.WIDTH(4)) b4 ();
    shift_reg_univ_if #(.WIDTH(8)) b8 ();

    shift_reg_univ #(.WIDTH(4)) u4 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b4.slave));
    shift_reg_univ #(.WIDTH(8)) u8 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b8.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word-level model: shifts as arithmetic on an integer, counter as a plain int.
    logic [31:0] m4_q, m8_q;
    logic        m4_sr, m4_sl, m4_done, m8_sr, m8_sl, m8_done;
    int          m4_cnt, m8_cnt;

    task automatic mstep(input int w, input logic clr, input logic [1:0] mode,
                         input logic sr_in, input logic sl_in, input logic rot,
                         input logic [31:0] pin,
                         inout logic [31:0] q, inout logic sr, inout logic sl,
                         inout int cnt, output logic done);
        logic fill;
        logic shifted;
        done    = 1'b0;
        shifted = 1'b0;
        if (clr) begin
            q = 0; sr = 0; sl = 0; cnt = 0;
        end else begin
            case (mode)
                2'b01: begin
                    fill = sr_in;
`ifdef SHIFT_ROTATE_EN
                    if (rot) fill = q[0];
`endif
                    sr = q[0];
                    q  = (q >> 1) | (32'(fill) << (w - 1));
                    shifted = 1'b1;
                end
                2'b10: begin
                    fill = sl_in;
`ifdef SHIFT_ROTATE_EN
                    if (rot) fill = q[w-1];
`endif
                    sl = q[w-1];
                    q  = ((q << 1) | 32'(fill)) & ((32'd1 << w) - 1);
                    shifted = 1'b1;
                end
                2'b11: begin
                    q   = pin;
                    cnt = 0;
                end
                default: ;
            endcase
            if (shifted) begin
                done = (cnt == w - 1);
                if (cnt < w) cnt++;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_q = 0; m4_sr = 0; m4_sl = 0; m4_cnt = 0; m4_done = 0;
            m8_q = 0; m8_sr = 0; m8_sl = 0; m8_cnt = 0; m8_done = 0;
        end else begin
            mstep(4, b4.clr, b4.mode, b4.sin_r, b4.sin_l, b4.rot, 32'(b4.pin),
                  m4_q, m4_sr, m4_sl, m4_cnt, m4_done);
            mstep(8, b8.clr, b8.mode, b8.sin_r, b8.sin_l, b8.rot, 32'(b8.pin),
                  m8_q, m8_sr, m8_sl, m8_cnt, m8_done);
        end
    end

    always @(negedge clk) begin
        chk("q4",      32'(b4.q),      m4_q);
        chk("sout_r4", 32'(b4.sout_r), 32'(m4_sr));
        chk("sout_l4", 32'(b4.sout_l), 32'(m4_sl));
        chk("cnt4",    32'(b4.cnt),    32'(m4_cnt));
        chk("done4",   32'(b4.done),   32'(m4_done));
        chk("q8",      32'(b8.q),      m8_q);
        chk("sout_r8", 32'(b8.sout_r), 32'(m8_sr));
        chk("sout_l8", 32'(b8.sout_l), 32'(m8_sl));
        chk("cnt8",    32'(b8.cnt),    32'(m8_cnt));
        chk("done8",   32'(b8.done),   32'(m8_done));
    end

    // Each step: inputs applied at a falling edge, result visible at the next falling edge.
    task automatic step4(input logic clr, input logic [1:0] mode, input logic sr,
                         input logic sl, input logic [3:0] pin, input logic rot);
        b4.clr = clr; b4.mode = mode; b4.sin_r = sr; b4.sin_l = sl; b4.pin = pin; b4.rot = rot;
        b8.clr = 1'b0; b8.mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step8(input logic clr, input logic [1:0] mode, input logic sr,
                         input logic sl, input logic [7:0] pin, input logic rot);
        b8.clr = clr; b8.mode = mode; b8.sin_r = sr; b8.sin_l = sl; b8.pin = pin; b8.rot = rot;
        b4.clr = 1'b0; b4.mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] pat;
    logic [7:0] dn;
    logic [1:0] md [8];
    int         cexp [8];

    initial begin
        b4.clr = 0; b4.mode = 0; b4.sin_r = 0; b4.sin_l = 0; b4.pin = 0; b4.rot = 0;
        b8.clr = 0; b8.mode = 0; b8.sin_r = 0; b8.sin_l = 0; b8.pin = 0; b8.rot = 0;
        @(negedge clk);
        chk("reset_q4", 32'(b4.q), 0);
        chk("reset_cnt4", 32'(b4.cnt), 0);
        rst_n = 1'b1;

        // Async reset mid-operation with q=1011 and sout_l=1
        step4(0, 2'b11, 0, 0, 4'b1101, 0);
        step4(0, 2'b10, 0, 1, 4'b0000, 0);
        chk("t1_q_pre", 32'(b4.q), 32'hB);
        chk("t1_soutl_pre", 32'(b4.sout_l), 1);
        chk("t1_cnt_pre", 32'(b4.cnt), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_q", 32'(b4.q), 0);
        chk("t1_sout_r", 32'(b4.sout_r), 0);
        chk("t1_sout_l", 32'(b4.sout_l), 0);
        chk("t1_cnt", 32'(b4.cnt), 0);
        chk("t1_done", 32'(b4.done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Right shift 1,0,1,0 then flush
        pat = 4'b1010;
        for (int i = 0; i < 4; i++) step4(0, 2'b01, pat[3-i], 0, 4'b0000, 0);
        chk("t2_q", 32'(b4.q), 32'h5);
        chk("t2_cnt", 32'(b4.cnt), 4);
        chk("t2_done", 32'(b4.done), 1);
        step4(0, 2'b00, 0, 0, 4'b0000, 0);
        chk("t2_done_hold", 32'(b4.done), 0);
        for (int i = 0; i < 4; i++) begin
            step4(0, 2'b01, 0, 0, 4'b0000, 0);
            chk("t2_sout_r", 32'(b4.sout_r), 32'(pat[3-i]));
            chk("t2_no_redone", 32'(b4.done), 0);
            chk("t2_cnt_sat", 32'(b4.cnt), 4);
        end

        // Load 1100, left shift with sin_l=1
        step4(0, 2'b11, 0, 0, 4'b1100, 0);
        chk("t3_load_q", 32'(b4.q), 32'hC);
        chk("t3_load_cnt", 32'(b4.cnt), 0);
        pat = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            step4(0, 2'b10, 0, 1, 4'b0000, 0);
            chk("t3_sout_l", 32'(b4.sout_l), 32'(pat[3-i]));
            chk("t3_cnt", 32'(b4.cnt), 32'(i + 1));
            chk("t3_done", 32'(b4.done), 32'(i == 3));
        end
        chk("t3_q", 32'(b4.q), 32'hF);

        // Holds inside a frame do not restart the count
        step4(0, 2'b11, 0, 0, 4'b0000, 0);
        md   = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
        cexp = '{1, 2, 2, 2, 2, 3, 4, 4};
        dn   = 8'b0100_0000;
        for (int i = 0; i < 8; i++) begin
            step4(0, md[i], 1, 0, 4'b0000, 0);
            chk("t4_cnt", 32'(b4.cnt), 32'(cexp[i]));
            chk("t4_done", 32'(b4.done), 32'(dn[i]));
        end

        // clr beats load, and a mid-frame clr restarts the frame
        step4(0, 2'b11, 0, 0, 4'b1010, 0);
        step4(1, 2'b11, 0, 0, 4'b1111, 0);
        chk("t5_q", 32'(b4.q), 0);
        chk("t5_cnt", 32'(b4.cnt), 0);
        step4(0, 2'b01, 1, 0, 4'b0000, 0);
        step4(0, 2'b01, 1, 0, 4'b0000, 0);
        step4(1, 2'b01, 1, 0, 4'b0000, 0);
        chk("t5_midclr_q", 32'(b4.q), 0);
        chk("t5_midclr_cnt", 32'(b4.cnt), 0);
        for (int i = 0; i < 4; i++) begin
            step4(0, 2'b01, 1, 0, 4'b0000, 0);
            chk("t5_done", 32'(b4.done), 32'(i == 3));
        end

        // WIDTH=8 rotate (or plain shift in the default build)
        step8(0, 2'b11, 0, 0, 8'h81, 0);
        for (int i = 0; i < 4; i++) step8(0, 2'b01, 0, 0, 8'h00, 1);
`ifdef SHIFT_ROTATE_EN
        chk("t6_q_half", 32'(b8.q), 32'h18);
`else
        chk("t6_q_half", 32'(b8.q), 32'h08);
`endif
        chk("t6_done_half", 32'(b8.done), 0);
        for (int i = 0; i < 4; i++) step8(0, 2'b01, 0, 0, 8'h00, 1);
`ifdef SHIFT_ROTATE_EN
        chk("t6_q_full", 32'(b8.q), 32'h81);
`else
        chk("t6_q_full", 32'(b8.q), 32'h00);
`endif
        chk("t6_done", 32'(b8.done), 1);
        step8(0, 2'b11, 0, 0, 8'h81, 0);
        step8(0, 2'b10, 0, 0, 8'h00, 1);
        step8(0, 2'b10, 0, 0, 8'h00, 1);
`ifdef SHIFT_ROTATE_EN
        chk("t6_rotl_q", 32'(b8.q), 32'h06);
`else
        chk("t6_rotl_q", 32'(b8.q), 32'h04);
`endif
        chk("t6_rotl_soutl", 32'(b8.sout_l), 0);

        step4(0, 2'b00, 0, 0, 4'b0000, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
